// File: rtl/cmp_seq_pkg.sv
// Shared types and helpers for the nibble-serial equality sequencer.
package cmp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // Nibble index width; a single-nibble word still needs a 1-bit index.
    function automatic int idx_width(input int width);
        int n;
        n = width / NIB_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_eq.sv
// Single 4-bit gate-level equality unit shared across all nibbles of a word.
module nibble_eq
    import cmp_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic             match
);

    assign match = &(~(a ^ b));

endmodule

// File: rtl/nibble_cmp_sequencer.sv
// Two-requester, time-shared wide-word equality checker scanning one nibble per cycle.
// Build option: define CMP_EARLY_EXIT_EN to stop scanning at the first mismatching nibble.
module nibble_cmp_sequencer
    import cmp_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             busy,
    output logic             gnt,
    output logic             done0,
    output logic             done1,
    output logic             eq
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             mis;
    logic             rr_last;
    logic             pick;
    logic             start;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic             nib_match;

    assign busy  = (state != IDLE);
    assign start = (state == IDLE) && (req0 || req1);

    // Round-robin only matters on contention: the requester not served last wins.
    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = ~rr_last;
        end
    end

    always_comb begin
        nib_a = a_q[idx*NIB_W +: NIB_W];
        nib_b = b_q[idx*NIB_W +: NIB_W];
    end

    nibble_eq u_nibble_eq (
        .a     (nib_a),
        .b     (nib_b),
        .match (nib_match)
    );

    // Operand capture at grant; data path carries no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            a_q <= pick ? a1 : a0;
            b_q <= pick ? b1 : b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            eq      <= 1'b0;
            rr_last <= 1'b1;
            idx     <= '0;
            mis     <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        gnt   <= pick;
                        idx   <= '0;
                        mis   <= 1'b0;
                        state <= CMP;
                    end
                end
                CMP: begin
`ifdef CMP_EARLY_EXIT_EN
                    if (!nib_match) begin
                        eq    <= 1'b0;
                        done0 <= ~gnt;
                        done1 <= gnt;
                        state <= DONE;
                    end else if (idx == LAST_IDX) begin
                        eq    <= ~mis;
                        done0 <= ~gnt;
                        done1 <= gnt;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
`else
                    if (idx == LAST_IDX) begin
                        eq    <= ~(mis | ~nib_match);
                        done0 <= ~gnt;
                        done1 <= gnt;
                        state <= DONE;
                    end else begin
                        mis <= mis | ~nib_match;
                        idx <= idx + 1'b1;
                    end
`endif
                end
                DONE: begin
                    rr_last <= gnt;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nibble_cmp_sequencer.md
# nibble_cmp_sequencer

Time-shared equality checker for two requesters. It arbitrates between the requesters and compares each granted pair of WIDTH-bit words one nibble per cycle through a single 4-bit equality unit. It then returns a one-cycle done pulse with the equality result. It lets every wide-word equality check in the design reuse one small gate-level comparator instead of replicating it per bit-slice.

## Interface
- WIDTH, 16, operand width; multiple of 4, minimum 4; NIB = WIDTH/4 nibbles
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, synchronous and active-high
- req0  in  1  requester 0 request; held high with a0/b0 stable until done0
- a0, b0  in  WIDTH  requester 0 operands
- req1  in  1  requester 1 request; held high with a1/b1 stable until done1
- a1, b1  in  WIDTH  requester 1 operands
- busy  out  1  high whenever state is not IDLE
- gnt  out  1  index of the current or most recent owner
- done0, done1  out  1  one-cycle completion pulse to the owner
- eq  out  1  result: 1 = all nibbles equal; valid with done, held until the next done

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise grant:
    - If only one requester is active, grant it.
    - If both are active, grant the one not served last (round-robin pointer; after reset req0 wins).
  - On the grant edge: latch the owner's a/b into internal registers, set gnt, clear nibble index idx to 0, go to CMP.
- CMP:
  - Each cycle, the comparator sees nibble idx of the latched operands, LSB nibble first.
  - Mismatch (early exit, see Configuration): record eq=0 and go to DONE.
  - Match on idx = NIB-1 with no prior mismatch: record eq=1 and go to DONE.
  - Otherwise idx increments.
- DONE:
  - Assert done[gnt] for exactly one cycle and update the round-robin pointer to gnt.
  - Return to IDLE.
- Operands are latched, so requester inputs may change after the grant without effect. Requesters must still hold req until done.
- A req still high in the IDLE cycle after DONE is a new request.
- idx width is max(1, $clog2(NIB)). idx never exceeds NIB-1, so there is no wrap-around.
- The mismatch flag accumulates in a sticky register, cleared at grant.

## Timing
- Reset values: busy=0, gnt=0, done0=done1=0, eq=0, state=IDLE, pointer favours req0.
- Request sampled in IDLE at cycle 0.
- Full match: CMP occupies cycles 1..NIB and done is high in cycle NIB+1. For WIDTH=16, done is in cycle 5.
- Early-exit mismatch at nibble i (0-based): done is high in cycle i+2.
- Back-to-back: the next grant is no earlier than the cycle after DONE. Minimum request-to-request spacing is 3 cycles.
- Simultaneous req0/req1 in IDLE: round-robin decides; the loser waits, with no starvation.
- Reset mid-operation:
  - Abandon the comparison; no done pulse.
  - All outputs and the pointer return to their reset values on the next edge.

## Configuration
- CMP_EARLY_EXIT_EN:
  - Defined: CMP ends on the first mismatching nibble (latency data-dependent, per Timing).
  - Undefined: all NIB nibbles are always scanned. done is always in cycle NIB+1 and eq is the AND of all nibble results.

## Structure
- Package cmp_seq_pkg holds:
  - the state enum (IDLE, CMP, DONE);
  - constant NIB_W = 4;
  - a function returning the idx width for a given WIDTH.
- One sub-module, nibble_eq:
  - 4-bit combinational equality, two 4-bit inputs, 1-bit output;
  - instantiated exactly once and fed by a nibble mux on idx.

## Test plan
- Reset, then idle 3 cycles: busy=0, gnt=0, eq=0, done0=done1=0 throughout.
- req0 only, a0=b0=16'hBEEF: done0 in cycle 5, eq=1, gnt=0, done1 never asserted.
- req1, a1=16'h1234, b1=16'h1294 (mismatch nibble 1):
  - With early exit: done1 in cycle 3, eq=0.
  - Without it: done1 in cycle 5, eq=0.
- req0 and req1 both high and held, all operands 16'h0000:
  - Grants alternate 0,1,0,1.
  - Each done is followed by the next grant one cycle later.
- Reset asserted in cycle 2 of a req0 comparison: no done0, busy=0 next cycle. A fresh req0 then completes normally in 5 cycles.
- WIDTH=4, a0=4'hA, b0=4'hA: done0 in cycle 2, eq=1.
